hatch_ctrl: RTL and testbench
=============================

HATCH_CTRL -- requirements
Module: hatch_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 1000: clk cycles per one-second tick.
REQ-002 SHALL have parameter STAGE_SEC, default 3: seconds spent in each hatch stage.
REQ-003 SHALL have parameter LAST_STAGE, default 11: final stage index, shown as the hatched chick.
REQ-004 SHALL have parameter FAULT_SEC, default 5: seconds of continuous bad temperature before failure.
REQ-005 SHALL have port clk, input, 1 bit: single clock, 1 kHz, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: debounced start/abort key level, synchronous to clk.
REQ-008 SHALL have port heat_ok, input, 1 bit: 1 = incubator temperature in range, synchronous to clk.
REQ-009 SHALL have port num, output, 4 bits: current hatch stage 0..LAST_STAGE, fed to the dot-matrix driver.
REQ-010 SHALL have port st, output, 1 bit: display enable; 0 blanks the dot-matrix driver.
REQ-011 SHALL have port temp, output, 1 bit: temperature-fault flag; 1 turns on the red overlay in the driver.
REQ-012 SHALL have ports done and fail, outputs, 1 bit each: status flags for the DONE and FAIL states.

Function
REQ-013 SHALL detect start rising edges internally (start=1 this cycle, 0 the previous cycle); only edges act, levels do not.
REQ-014 SHALL implement a five-state machine with states IDLE, HATCH, HOLD, DONE and FAIL.
REQ-015 SHALL register all outputs, so a transition decided at edge N is visible on the outputs after edge N.
REQ-016 SHALL give a start edge priority over every other transition in the same cycle.
REQ-017 IDLE SHALL drive st=0, num=0, temp=0, done=0, fail=0.
REQ-018 IDLE SHALL, on a start edge, go to HATCH with num=0, prescaler=0 and stage_sec=0.
REQ-019 HATCH SHALL drive st=1 and temp=0.
REQ-020 HATCH SHALL run the prescaler 0..CLK_HZ-1 and emit a tick when the prescaler equals CLK_HZ-1, then wrap it to 0.
REQ-021 HATCH SHALL, on each tick, increment stage_sec; when stage_sec equals STAGE_SEC-1 it SHALL clear stage_sec and increment num.
REQ-022 HATCH SHALL go to DONE in the same cycle that num becomes LAST_STAGE.
REQ-023 HATCH SHALL, when heat_ok=0, go to HOLD with fault_sec=0; a coincident tick is ignored, and num and stage_sec are held.
REQ-024 HATCH SHALL, on a start edge, abort to IDLE.
REQ-025 HOLD SHALL drive st=1 and temp=1, and hold num and stage_sec frozen.
REQ-026 HOLD SHALL keep the prescaler running and increment fault_sec on each tick.
REQ-027 HOLD SHALL, when heat_ok=1, return to HATCH with fault_sec cleared and stage_sec preserved; this takes priority over a coincident tick.
REQ-028 HOLD SHALL go to FAIL on the tick where fault_sec equals FAULT_SEC-1.
REQ-029 HOLD SHALL, on a start edge, go to IDLE.
REQ-030 DONE SHALL drive num=LAST_STAGE, st=1, temp=0, done=1, and ignore heat_ok.
REQ-031 DONE SHALL go to IDLE on a start edge.
REQ-032 FAIL SHALL hold num, drive st=1, temp=1, fail=1, and ignore heat_ok.
REQ-033 FAIL SHALL go to IDLE on a start edge.
REQ-034 SHALL clear the prescaler in IDLE, DONE and FAIL; all counters SHALL be wide enough for their parameter maxima with no overflow.
REQ-035 SHALL never drive num above LAST_STAGE.

Reset
REQ-036 rst=1 at a clk edge SHALL force IDLE in every state and clear num, stage_sec, fault_sec, the prescaler and the edge-detect register; outputs SHALL be st=0, temp=0, done=0, fail=0, num=0 after that edge.
REQ-037 rst SHALL take priority over a start edge in the same cycle.
REQ-038 After rst is released, start already high SHALL NOT produce an edge until start has been sampled low.

Verification (defaults)
REQ-039 Normal hatch: start pulse, heat_ok=1 -> num=1 exactly 3000 cycles after the HATCH-entry edge; num=11, done=1 after 33000 cycles; st=1 throughout.
REQ-040 Pause/resume: heat_ok=0 for 2000 cycles mid-stage, then 1 -> temp=1 during the gap; num frozen; stage completion delayed by the gap, within one-tick quantisation.
REQ-041 Fault: heat_ok=0 held from HATCH -> FAIL after 5000 cycles with temp=1, fail=1, num unchanged; start edge -> IDLE with st=0, num=0.
REQ-042 Abort: start edge at num=4 in HATCH -> next cycle st=0, num=0; a following start edge restarts at num=0.
REQ-043 Reset mid-HOLD with start held high -> IDLE, all outputs 0; no restart until start has gone low then high.
REQ-044 Coincidence: heat_ok falling on the tick that completes a stage -> HOLD, num not incremented; start edge coinciding with a tick in HATCH -> IDLE.

Source files
------------

// File: rtl/hatch_ctrl.sv
// hatch_ctrl: incubator hatch-stage sequencer with a temperature hold and fault timeout.
module hatch_ctrl #(
   parameter int CLK_HZ     = 1000,
   parameter int STAGE_SEC  = 3,
   parameter int LAST_STAGE = 11,
   parameter int FAULT_SEC  = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       heat_ok,
   output logic [3:0] num,
   output logic       st,
   output logic       temp,
   output logic       done,
   output logic       fail
);
   localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
   localparam int SW = $clog2(STAGE_SEC + 1);
   localparam int FW = $clog2(FAULT_SEC + 1);
   typedef enum logic [2:0] {IDLE, HATCH, HOLD, DONE, FAIL} state_t;
   state_t state, state_n;
   logic [PW-1:0] presc, presc_n;
   logic [SW-1:0] stage_sec, stage_n;
   logic [FW-1:0] fault_sec, fault_n;
   logic [3:0] num_n;
   logic start_q, armed, start_edge, tick;
   // armed stays low after reset until start is seen low, so a held key cannot restart
   assign start_edge = start & ~start_q & armed;
   assign tick = presc == PW'(CLK_HZ - 1);
   always_comb begin
      state_n = state;
      presc_n = '0;
      stage_n = stage_sec;
      fault_n = fault_sec;
      num_n = num;
      if (start_edge) begin
         state_n = state == IDLE ? HATCH : IDLE;
         num_n = '0;
         stage_n = '0;
         fault_n = '0;
      end else if (state == HATCH || state == HOLD) begin
         presc_n = tick ? '0 : presc + 1'b1;
         if (state == HATCH && !heat_ok) begin
            state_n = HOLD;
            fault_n = '0;
         end else if (state == HOLD && heat_ok) begin
            state_n = HATCH;
            fault_n = '0;
         end else if (tick && state == HATCH) begin
            if (stage_sec == SW'(STAGE_SEC - 1)) begin
               stage_n = '0;
               num_n = num + 1'b1;
               state_n = (num + 1'b1) == 4'(LAST_STAGE) ? DONE : HATCH;
            end else begin
               stage_n = stage_sec + 1'b1;
            end
         end else if (tick) begin
            state_n = fault_sec == FW'(FAULT_SEC - 1) ? FAIL : HOLD;
            fault_n = fault_sec == FW'(FAULT_SEC - 1) ? fault_sec : fault_sec + 1'b1;
         end
      end else if (state == DONE) begin
         num_n = 4'(LAST_STAGE);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         presc <= '0;
         stage_sec <= '0;
         fault_sec <= '0;
         num <= '0;
         start_q <= 1'b0;
         armed <= 1'b0;
         st <= 1'b0;
         temp <= 1'b0;
         done <= 1'b0;
         fail <= 1'b0;
      end else begin
         state <= state_n;
         presc <= presc_n;
         stage_sec <= stage_n;
         fault_sec <= fault_n;
         num <= num_n;
         start_q <= start;
         armed <= armed | ~start;
         st <= state_n != IDLE;
         temp <= state_n == HOLD || state_n == FAIL;
         done <= state_n == DONE;
         fail <= state_n == FAIL;
      end
   end
endmodule

// File: tb/tb_hatch_ctrl.sv
// tb_hatch_ctrl: directed scenarios; expectations queued by cycle and checked by a monitor.
module tb_hatch_ctrl;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, heat_ok = 1'b1;
   logic [3:0] num;
   logic st, temp, done, fail;
   int cyc = 0, checks = 0, failures = 0;
   int qc[$];
   logic [7:0] qv[$];
   string qn[$];
   hatch_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .heat_ok(heat_ok),
      .num(num), .st(st), .temp(temp), .done(done), .fail(fail)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [7:0] v(int n, bit s, bit t, bit d, bit f);
      return {4'(n), s, t, d, f};
   endfunction
   task automatic expect_at(string n, int c, logic [7:0] x);
      qn.push_back(n);
      qc.push_back(c);
      qv.push_back(x);
   endtask
   task automatic wait_to(int c);
      while (cyc < c) @(negedge clk);
   endtask
   task automatic start_at(int c);
      wait_to(c - 1);
      start = 1'b1;
   endtask
   task automatic release_start;
      @(negedge clk);
      start = 1'b0;
   endtask
   // monitor: compares outputs against every expectation whose cycle has arrived
   always @(negedge clk) begin
      while (qc.size() != 0 && qc[0] <= cyc) begin
         checks = checks + 1;
         if (qc[0] != cyc || {num, st, temp, done, fail} != qv[0]) begin
            failures = failures + 1;
            $display("FAIL %s cyc=%0d due=%0d got{num,st,temp,done,fail}=%h want=%h",
                     qn[0], cyc, qc[0], {num, st, temp, done, fail}, qv[0]);
         end
         qc.delete(0);
         qv.delete(0);
         qn.delete(0);
      end
   end
   initial begin
      #1_500_000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "timeout");
   end
   initial begin
      int e;
      repeat (3) @(negedge clk);
      expect_at("reset", cyc + 1, v(0, 0, 0, 0, 0));
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      // normal hatch through DONE, heat ignored in DONE, abort from DONE
      e = cyc + 1;
      start_at(e);
      expect_at("hatch_entry", e, v(0, 1, 0, 0, 0));
      expect_at("pre_stage1", e + 2999, v(0, 1, 0, 0, 0));
      expect_at("stage1", e + 3000, v(1, 1, 0, 0, 0));
      expect_at("pre_done", e + 32999, v(10, 1, 0, 0, 0));
      expect_at("done", e + 33000, v(11, 1, 0, 1, 0));
      expect_at("done_heat", e + 33010, v(11, 1, 0, 1, 0));
      expect_at("done_abort", e + 33020, v(0, 0, 0, 0, 0));
      release_start;
      wait_to(e + 33002);
      heat_ok = 1'b0;
      wait_to(e + 33012);
      heat_ok = 1'b1;
      start_at(e + 33020);
      release_start;
      // pause/resume mid-stage, then abort on a tick at num=4
      repeat (3) @(negedge clk);
      e = cyc + 1;
      start_at(e);
      expect_at("hold_enter", e + 1500, v(0, 1, 1, 0, 0));
      expect_at("hold_frozen", e + 3499, v(0, 1, 1, 0, 0));
      expect_at("resume", e + 3500, v(0, 1, 0, 0, 0));
      expect_at("late_pre", e + 4999, v(0, 1, 0, 0, 0));
      expect_at("late_stage1", e + 5000, v(1, 1, 0, 0, 0));
      expect_at("pre_abort", e + 14999, v(4, 1, 0, 0, 0));
      expect_at("abort", e + 15000, v(0, 0, 0, 0, 0));
      release_start;
      wait_to(e + 1499);
      heat_ok = 1'b0;
      wait_to(e + 3499);
      heat_ok = 1'b1;
      start_at(e + 15000);
      release_start;
      // restart, heat loss on a stage-completing tick, then fault timeout
      repeat (2) @(negedge clk);
      e = cyc + 1;
      start_at(e);
      expect_at("restart", e, v(0, 1, 0, 0, 0));
      expect_at("coinc_hold", e + 6000, v(1, 1, 1, 0, 0));
      expect_at("pre_fail", e + 10999, v(1, 1, 1, 0, 0));
      expect_at("fail", e + 11000, v(1, 1, 1, 0, 1));
      expect_at("fail_heat", e + 11010, v(1, 1, 1, 0, 1));
      expect_at("fail_abort", e + 11020, v(0, 0, 0, 0, 0));
      release_start;
      wait_to(e + 5999);
      heat_ok = 1'b0;
      wait_to(e + 11004);
      heat_ok = 1'b1;
      start_at(e + 11020);
      release_start;
      // reset in HOLD with start rising and held high afterwards
      repeat (2) @(negedge clk);
      e = cyc + 1;
      start_at(e);
      expect_at("r_hatch", e, v(0, 1, 0, 0, 0));
      expect_at("r_hold", e + 10, v(0, 1, 1, 0, 0));
      expect_at("r_reset", e + 20, v(0, 0, 0, 0, 0));
      expect_at("r_released", e + 30, v(0, 0, 0, 0, 0));
      expect_at("r_held", e + 44, v(0, 0, 0, 0, 0));
      expect_at("r_pre_restart", e + 49, v(0, 0, 0, 0, 0));
      expect_at("r_restart", e + 50, v(0, 1, 0, 0, 0));
      release_start;
      wait_to(e + 9);
      heat_ok = 1'b0;
      wait_to(e + 19);
      start = 1'b1;
      rst = 1'b1;
      wait_to(e + 21);
      rst = 1'b0;
      heat_ok = 1'b1;
      wait_to(e + 44);
      start = 1'b0;
      wait_to(e + 49);
      start = 1'b1;
      release_start;
      wait_to(e + 52);
      for (int i = 0; i < 20 && qc.size() != 0; i++) @(negedge clk);
      if (qc.size() != 0) begin
         failures = failures + qc.size();
         $display("FAIL drain pending=%0d required=0", qc.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
